// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b (LSB first, one registered borrow) with start/busy/done handshake; ports clk, rst (async, high), start, a, b, [add when SERIAL_SUB_ADD_MODE_EN], busy, done, diff, bout
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             add,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, sh;
  logic [WIDTH-2:0] wr;
  logic [CW-1:0] cnt;
  logic br, x, y, d, br_next, op_add;
`ifndef SERIAL_SUB_ADD_MODE_EN
  assign op_add = 1'b0;
`endif
  always_comb begin
    x = a_sr[0];
    y = b_sr[0];
    d = x ^ y ^ br;
    br_next = op_add ? (x & y) | ((x ^ y) & br) : (~x & y) | (~(x ^ y) & br);
    sh = {d, wr};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      a_sr <= '0;
      b_sr <= '0;
      wr <= '0;
      cnt <= '0;
      br <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_add <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
          a_sr <= a;
          b_sr <= b;
          br <= 1'b0;
          cnt <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
          op_add <= add;
`endif
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          wr <= sh[WIDTH-1:1];
          br <= br_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            diff <= sh;
            bout <= br_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench against an arithmetic reference model
module tb_serial_subtractor;
  localparam int W = 8;
`ifdef SERIAL_SUB_ADD_MODE_EN
  localparam bit HAS_ADD = 1'b1;
`else
  localparam bit HAS_ADD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_add = 1'b0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic busy, done, bout;
  int n_checks = 0, n_pass = 0;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .add(op_add),
`endif
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ad);
    longint xl, yl, r;
    xl = longint'(x);
    yl = longint'(y);
    r = ad ? xl + yl : xl - yl;
    return {ad ? (r >= (longint'(1) << W)) : (xl < yl), r[W-1:0]};
  endfunction
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ad, input bit noise);
    logic [W-1:0] prev;
    logic prevb;
    logic [W:0] e;
    int busy_n, k;
    bit held, both, seen;
    @(negedge clk);
    a = ta; b = tb; op_add = ad; start = 1'b1;
    prev = diff; prevb = bout;
    e = model(ta, tb, ad);
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; held = 1'b1; both = 1'b0; seen = 1'b0;
    for (k = 1; k <= W + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (busy && done) both = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (diff !== prev || bout !== prevb) held = 1'b0;
      if (noise) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        op_add = 1'($urandom);
      end
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", k, W + 1);
    check("busy_cycles", busy_n, W);
    check("result_held", 32'(held), 1);
    check("busy_done_excl", 32'(both), 0);
    check("diff", 32'(diff), 32'(e[W-1:0]));
    check("bout", 32'(bout), 32'(e[W]));
    if (noise) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after", {30'b0, busy, done}, 0);
  endtask
  initial begin
    int t0, t1, c;
    bit saw;
    logic [W-1:0] ra, rb;
    logic rad;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_bout", 32'(bout), 0);
    rst = 1'b0;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    check("dir_5a_3c", 32'(diff), 32'h1E);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    check("dir_00_01", {23'b0, bout, diff}, 32'h1FF);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'hC3, 8'h41, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'h37; b = 8'h12; start = 1'b1;
    t0 = -1; t1 = -1;
    for (c = 0; c < 4 * (W + 2) && t1 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_diff", 32'(diff), 32'h25);
        if (t0 < 0) t0 = c;
        else t1 = c;
      end
    end
    start = 1'b0;
    check("b2b_period", t1 - t0, W + 2);
    repeat (W + 3) @(negedge clk);
    run_op(8'hF0, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_diff", 32'(diff), 0);
    check("abort_bout", 32'(bout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (3 * W) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    check("abort_no_done", 32'(saw), 0);
    run_op(8'h10, 8'h01, 1'b0, 1'b0);
    check("post_abort", 32'(diff), 32'h0F);
    if (HAS_ADD) begin
      run_op(8'hFF, 8'h01, 1'b1, 1'b0);
      check("add_ff_01", {23'b0, bout, diff}, 32'h100);
      run_op(8'h05, 8'h07, 1'b0, 1'b0);
      check("sub_05_07", {23'b0, bout, diff}, 32'h1FE);
    end
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      rb = (i % 8 == 0) ? ra : W'($urandom);
      rad = HAS_ADD ? 1'($urandom) : 1'b0;
      run_op(ra, rb, rad, ($urandom % 4) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor: computes `a - b` one bit per clock, LSB first, using a single registered borrow bit instead of a WIDTH-wide ripple chain. It sits beside the combinational adder datapath as its area-minimal counterpart for non-time-critical arithmetic, such as counters, compare logic and calibration math. A start/busy/done handshake controls it, and the result is held stable until the next accepted operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  input  1  sole clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge.
- `add`  input  1  present only when `SERIAL_SUB_ADD_MODE_EN` is defined; 1 = `a + b`, 0 = `a - b`; sampled on the accepting edge.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; result valid.
- `diff`  output  WIDTH  result register.
- `bout`  output  1  borrow out: 1 iff `a < b` unsigned. In add mode it is the carry out.
- Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1. This loads the operand shift registers from `a`/`b`, clears the borrow flop and clears the bit counter to 0.
- Each RUN cycle processes bit i, taking x = `a_sr[0]` and y = `b_sr[0]`:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
  - d is shifted into the MSB of the working register and `a_sr`/`b_sr` shift right.
  - The counter increments.
- Add mode (macro only) uses carry_next = (x & y) | ((x ^ y) & br) instead.
- RUN -> DONE on the cycle the counter reaches WIDTH-1, i.e. after WIDTH bit-steps. On that same edge, the working register plus final d are copied to `diff`, and the final br_next is copied to `bout`.
- DONE -> IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored and is not queued.
- `diff`/`bout` keep the previous result throughout RUN. They change only on the RUN->DONE edge or on reset.
- Arithmetic is modulo 2^WIDTH. There is no signed-overflow output.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `bout`=0, counter and borrow 0.
- Asserting `rst` mid-RUN aborts immediately. No `done` is produced, and the partial result is discarded.
- Latency: `start` is sampled at edge E. `busy` is high from after E until after edge E+WIDTH. `done` is high for exactly the cycle between edges E+WIDTH and E+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is at edge E+WIDTH+2, once the block is back in IDLE.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `SERIAL_SUB_ADD_MODE_EN` defined:
  - The `add` port exists and the operation is latched at accept.
  - `add`=1 selects addition with carry-out on `bout`.
  - `add`=0 is identical to subtract-only behaviour.
- `SERIAL_SUB_ADD_MODE_EN` undefined: there is no `add` port and the block always subtracts.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `start` pulse:
  - `busy` is high for 8 cycles.
  - `done` pulses 8 edges after accept.
  - `diff`=0x1E and `bout`=0.
- `a`=0x00, `b`=0x01 -> `diff`=0xFF, `bout`=1. Then `a`=0x80, `b`=0x80 -> `diff`=0x00, `bout`=0.
- Back-to-back:
  - `start` held high continuously gives a new accept every 10 cycles.
  - `start` pulses during RUN/DONE are ignored.
  - `diff` stays at the prior result until the next `done`.
- `rst` asserted at bit 4 of an operation:
  - All outputs are 0 asynchronously and no `done` is produced.
  - The next operation, 0x10-0x01, yields 0x0F.
- Random sweep of 10k operand pairs for WIDTH=8 and WIDTH=13: `diff` == (a-b) mod 2^WIDTH and `bout` == (a<b) on every `done`.
- With `SERIAL_SUB_ADD_MODE_EN`:
  - `add`=1, 0xFF+0x01 -> `diff`=0x00, `bout`=1.
  - `add`=0, 0x05-0x07 -> `diff`=0xFE, `bout`=1.
